i2s_tx_serializer: RTL and testbench

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

---
 rtl/i2s_tx_serializer.sv | 109 ++++++++++
 tb/tb_i2s_tx_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: a one-pair holding buffer feeds a 64-BCLK stereo frame.
// Each frame sends 16-bit left/right words MSB first, one BCLK after the word-select edge.
module i2s_tx_serializer #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bclk,
    output logic        l_r_clk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div;
    logic        bclk_q;
    logic [5:0]  bit_cnt;
    logic        full;
    logic [15:0] buf_l, buf_r;
    logic [15:0] tx_l, tx_r;
    logic        lr_q, sd_q, fs_q, ur_q;

    logic        div_wrap, fall, boundary, accept;
    logic [5:0]  bit_nxt;
    logic [4:0]  slot;
    logic [15:0] sample;
    logic        sd_nxt;

    // Handshake: a pair transfers on any cycle with in_valid && in_ready.
    // in_ready depends only on the registered buffer state, never on in_valid.
    assign accept   = in_valid && !full;
    assign div_wrap = (div == DIV_LAST);
    assign fall     = div_wrap && bclk_q;
    assign boundary = fall && (bit_cnt == 6'd63);
    assign bit_nxt  = bit_cnt + 6'd1;
    assign slot     = bit_nxt[4:0];

    always_comb begin
        sample = bit_nxt[5] ? tx_r : tx_l;
        sd_nxt = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16)
            sd_nxt = sample[4'(5'd16 - slot)];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= 8'd0;
            bclk_q <= 1'b0;
        end else if (div_wrap) begin
            div    <= 8'd0;
            bclk_q <= ~bclk_q;
        end else begin
            div    <= div + 8'd1;
        end
    end

    // Serial outputs move only on BCLK falling events so the DAC samples mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 6'd63;
            lr_q    <= 1'b0;
            sd_q    <= 1'b0;
        end else if (fall) begin
            bit_cnt <= bit_nxt;
            lr_q    <= bit_nxt[5];
            sd_q    <= sd_nxt;
        end
    end

    // The boundary sees the pre-cycle buffer state; a same-cycle accept waits for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            buf_l <= 16'd0;
            buf_r <= 16'd0;
            tx_l  <= 16'd0;
            tx_r  <= 16'd0;
            fs_q  <= 1'b0;
            ur_q  <= 1'b0;
        end else begin
            fs_q <= boundary;
            ur_q <= boundary && !full;
            if (boundary && full) begin
                tx_l <= buf_l;
                tx_r <= buf_r;
                full <= 1'b0;
            end
            if (accept) begin
                buf_l <= left_in;
                buf_r <= right_in;
                full  <= 1'b1;
            end
        end
    end

    assign in_ready    = !full;
    assign bclk        = bclk_q;
    assign l_r_clk     = lr_q;
    assign sdata       = sd_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer with BCLK_DIV=2: directed scenarios plus random traffic,
// every clock compared against a frame-level timeline model.
module tb_i2s_tx_serializer;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] left_in = 16'd0;
    logic [15:0] right_in = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, bclk, l_r_clk, sdata, frame_start, underrun;

    i2s_tx_serializer #(.BCLK_DIV(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .left_in     (left_in),
        .right_in    (right_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bclk        (bclk),
        .l_r_clk     (l_r_clk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time in clk edges since reset release, and the pair state.
    int          t;
    int          m_b;
    int          s;
    bit          bnd;
    bit          m_full;
    bit          m_acc;
    logic [15:0] m_bl, m_br, m_tl, m_tr, smp;
    logic        e_bclk, e_lr, e_sd, e_fs, e_ur, e_rdy;
    int          p;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bclk", 16'(bclk), 16'(e_bclk));
        chk("l_r_clk", 16'(l_r_clk), 16'(e_lr));
        chk("sdata", 16'(sdata), 16'(e_sd));
        chk("frame_start", 16'(frame_start), 16'(e_fs));
        chk("underrun", 16'(underrun), 16'(e_ur));
        chk("in_ready", 16'(in_ready), 16'(e_rdy));
    endtask

    // One clk: update the model at the edge, compare on the falling clk edge.
    task automatic step();
        @(posedge clk);
        t++;
        bnd   = (t >= 2*D) && (((t - 2*D) % (128*D)) == 0);
        m_acc = in_valid && !m_full;
        e_fs  = bnd;
        e_ur  = bnd && !m_full;
        if (bnd && m_full) begin
            m_tl   = m_bl;
            m_tr   = m_br;
            m_full = 1'b0;
        end
        if (m_acc) begin
            m_bl   = left_in;
            m_br   = right_in;
            m_full = 1'b1;
        end
        e_rdy  = !m_full;
        e_bclk = ((t / D) % 2) == 1;
        if (t < 2*D) begin
            m_b  = 63;
            e_lr = 1'b0;
            e_sd = 1'b0;
        end else begin
            m_b  = ((t - 2*D) / (2*D)) % 64;
            s    = m_b % 32;
            e_lr = (m_b >= 32);
            smp  = e_lr ? m_tr : m_tl;
            e_sd = (s >= 1 && s <= 16) ? smp[16 - s] : 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        t = 0; m_b = 63; m_full = 1'b0; m_acc = 1'b0;
        m_tl = 16'd0; m_tr = 16'd0; m_bl = 16'd0; m_br = 16'd0;
        e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_fs = 1'b0; e_ur = 1'b0; e_rdy = 1'b1;
        check_all();
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        left_in  = l;
        right_in = r;
        in_valid = 1'b1;
        for (int i = 0; i < 200*D; i++) begin
            step();
            if (m_acc) break;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);

        // Idle after reset: sdata stays 0, underrun with every frame_start.
        do_reset();
        run(2*D + 2*128*D + 10);

        // Directed pair before the first boundary.
        do_reset();
        send(16'hA5C3, 16'h0001);
        run(2*128*D + 4);

        // One pair, then a starved frame that must repeat it.
        send(16'h7FFF, 16'h8000);
        run(3*128*D);

        // in_valid held high with an incrementing pattern.
        p        = 1;
        left_in  = 16'(p);
        right_in = 16'(p + 1);
        in_valid = 1'b1;
        for (int i = 0; i < 4*128*D; i++) begin
            step();
            if (m_acc) begin
                p        = p + 2;
                left_in  = 16'(p);
                right_in = 16'(p + 1);
            end
        end
        in_valid = 1'b0;
        run(2*128*D);

        // Offer a pair exactly in the boundary cycle with an empty buffer.
        for (int i = 0; i < 300*D; i++) begin
            if (!m_full && (t + 1 >= 2*D) && (((t + 1 - 2*D) % (128*D)) == 0)) break;
            step();
        end
        left_in  = 16'($urandom);
        right_in = 16'($urandom);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run(2*128*D + 4);

        // Random pairs at random intervals.
        for (int i = 0; i < 6*128*D; i++) begin
            if (!in_valid && $urandom_range(0, 199) == 0) begin
                left_in  = 16'($urandom);
                right_in = 16'($urandom);
                in_valid = 1'b1;
            end
            step();
            if (m_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;

        // Reset mid-frame at bit 40 with a full buffer; the held pair is dropped.
        send(16'h1234, 16'hFEDC);
        send(16'h5A5A, 16'hC3C3);
        for (int i = 0; i < 300*D; i++) begin
            if (m_b == 40 && t >= 2*D) break;
            step();
        end
        #2;
        do_reset();
        run(2*D + 128*D + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
